// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions.
package fpu_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple segments.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_seg.sv
// K-bit ripple-carry segment: one pipeline stage worth of the carry chain,
// with the carry into its MSB exposed for overflow detection.
module rca_seg #(
   parameter int K = 8
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         cin,
   output logic [K-1:0] s,
   output logic         cout,
   output logic         cmsb,
   output logic         zero
);

   logic [K:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < K; i++) begin : g_bit
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   assign cout = c[K];
   assign cmsb = c[K-1];
   assign zero = (s == '0);

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into K-bit segments,
// one per stage, with operand skew in front and result deskew behind.
module pipelined_addsub
   import fpu_pkg::*;
#(
   parameter int N = 32,
   parameter int K = 8
) (
   input  logic         CLOCK_50,
   input  logic         RESET_N,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         SUB,
   input  logic         Cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] S,
   output logic         Cout,
   output logic         OVF,
   output logic         ZERO
);

   localparam int STAGES = N / K;

   if (N % K != 0) begin : g_bad_width
      $error("pipelined_addsub: N (%0d) must be a multiple of K (%0d)", N, K);
   end

   logic              adv;
   logic              vin;
   logic [STAGES-1:0] vld_d, vld_q;
   logic [STAGES-1:0] ld;
   logic [STAGES-1:0] carry_w, zero_w;
   logic [N-1:0]      be;
   logic              c0;

   assign be = (SUB == MODE_SUB) ? ~B : B;
   assign c0 = (SUB == MODE_SUB) ? 1'b1 : Cin;

   // A pipeline slot loads only when the global enable is up and a beat is
   // arriving, so S and flags keep the last result while out_valid is low.
   always_comb begin
      adv      = !vld_q[STAGES-1] || out_ready;
      in_ready = adv;
      vin      = 1'b0;
      for (int p = 0; p < STAGES; p++) begin
         vin      = (p == 0) ? in_valid : vld_q[(p == 0) ? 0 : p - 1];
         ld[p]    = adv && vin;
         vld_d[p] = adv ? vin : vld_q[p];
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign Cout      = carry_w[STAGES-1];
   assign ZERO      = zero_w[STAGES-1];

   for (genvar j = 0; j < STAGES; j++) begin : g_seg
      logic [K-1:0] a_op, b_op, s_seg;
      logic [K-1:0] sum_d, sum_q;
      logic         c_in, z_in, co_seg, cm_seg, z_seg;
      logic         carry_d, carry_q, zero_d, zero_q;

      // Input skew: segment j waits j slots for the carry of segment j-1.
      if (j == 0) begin : g_head
         assign a_op = A[K-1:0];
         assign b_op = be[K-1:0];
         assign c_in = c0;
         assign z_in = 1'b1;
      end else begin : g_skew
         logic [K-1:0] a_sk_d [j];
         logic [K-1:0] a_sk_q [j];
         logic [K-1:0] b_sk_d [j];
         logic [K-1:0] b_sk_q [j];

         always_comb begin
            a_sk_d[0] = ld[0] ? A[j*K +: K]  : a_sk_q[0];
            b_sk_d[0] = ld[0] ? be[j*K +: K] : b_sk_q[0];
            for (int m = 1; m < j; m++) begin
               a_sk_d[m] = ld[m] ? a_sk_q[m-1] : a_sk_q[m];
               b_sk_d[m] = ld[m] ? b_sk_q[m-1] : b_sk_q[m];
            end
         end

         always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
               for (int m = 0; m < j; m++) begin
                  a_sk_q[m] <= '0;
                  b_sk_q[m] <= '0;
               end
            end else begin
               a_sk_q <= a_sk_d;
               b_sk_q <= b_sk_d;
            end
         end

         assign a_op = a_sk_q[j-1];
         assign b_op = b_sk_q[j-1];
         assign c_in = carry_w[j-1];
         assign z_in = zero_w[j-1];
      end

      rca_seg #(.K(K)) u_seg (
         .a    (a_op),
         .b    (b_op),
         .cin  (c_in),
         .s    (s_seg),
         .cout (co_seg),
         .cmsb (cm_seg),
         .zero (z_seg)
      );

      // Stage j register: sum segment, carry to stage j+1, running zero flag.
      always_comb begin
         sum_d   = ld[j] ? s_seg            : sum_q;
         carry_d = ld[j] ? co_seg           : carry_q;
         zero_d  = ld[j] ? (z_in & z_seg)   : zero_q;
      end

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
         if (!RESET_N) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
         end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
         end
      end

      assign carry_w[j] = carry_q;
      assign zero_w[j]  = zero_q;

      // Output deskew: earlier segments wait until the top segment is done.
      if (j == STAGES - 1) begin : g_tail
         logic ovf_d, ovf_q;

         always_comb ovf_d = ld[j] ? (cm_seg ^ co_seg) : ovf_q;

         always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
               ovf_q <= 1'b0;
            end else begin
               ovf_q <= ovf_d;
            end
         end

         assign OVF          = ovf_q;
         assign S[j*K +: K]  = sum_q;
      end else begin : g_deskew
         localparam int D = STAGES - 1 - j;
         logic [K-1:0] ds_d [D];
         logic [K-1:0] ds_q [D];
         logic         unused_cm;

         assign unused_cm = cm_seg;

         always_comb begin
            ds_d[0] = ld[j+1] ? sum_q : ds_q[0];
            for (int m = 1; m < D; m++) begin
               ds_d[m] = ld[j+1+m] ? ds_q[m-1] : ds_q[m];
            end
         end

         always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
               for (int m = 0; m < D; m++) begin
                  ds_q[m] <= '0;
               end
            end else begin
               ds_q <= ds_d;
            end
         end

         assign S[j*K +: K] = ds_q[D-1];
      end
   end

endmodule
